// File: rtl/mips_trace_capture.sv
// mips_trace_capture
// Commit-trace monitor for the single-cycle MIPS core debug outputs.
// Every architectural side effect (writeback to a non-zero register, or a
// data-memory store) is queued in a small FIFO. Queued events leave on a
// 32-bit valid/ready stream as 3-word records: header, PC, value.
// Events lost to a full FIFO are counted. The count is reported in the
// header of the next record that is popped.
//
// Ports:
//   clk         sole clock, rising edge
//   reset       synchronous, active-high
//   enable      capture enable (draining continues while low)
//   pc_out      PC of the instruction in the current cycle
//   reg_write   register writeback this cycle
//   write_reg   destination register index
//   write_data  writeback value
//   mem_write   store this cycle
//   alu_result  store address when mem_write=1
//   out_valid   out_data holds a valid record word (registered)
//   out_ready   consumer accepts the word
//   out_data    record word (registered)
//   fifo_count  current FIFO occupancy
module mips_trace_capture #(
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     enable,
   input  logic [31:0]              pc_out,
   input  logic                     reg_write,
   input  logic [4:0]               write_reg,
   input  logic [31:0]              write_data,
   input  logic                     mem_write,
   input  logic [31:0]              alu_result,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [31:0]              out_data,
   output logic [$clog2(DEPTH):0]   fifo_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_HDR, S_PC, S_VAL} state_t;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   // FIFO storage (data only, never reset; pointers/count qualify it)
   logic          r_mem_type [DEPTH];
   logic [4:0]    r_mem_reg  [DEPTH];
   logic [7:0]    r_mem_seq  [DEPTH];
   logic [31:0]   r_mem_pc   [DEPTH];
   logic [31:0]   r_mem_val  [DEPTH];

   logic [AW-1:0] r_wptr;
   logic [AW-1:0] r_rptr;
   logic [CW-1:0] r_count;
   logic [7:0]    r_seq;
   logic [7:0]    r_drop;

   state_t        r_state;
   state_t        w_state_nxt;
   logic          r_out_valid;
   logic [31:0]   r_out_data;
   logic [31:0]   r_cur_pc;
   logic [31:0]   r_cur_val;

   logic          w_reg_evt;
   logic          w_st_evt;
   logic          w_evt;
   logic          w_full;
   logic          w_empty;
   logic          w_push;
   logic          w_drop;
   logic          w_pop;
   logic          w_xfer;
   logic          w_load_hdr;
   logic          w_load_pc;
   logic          w_load_val;
   logic          w_clr_valid;
   logic [31:0]   w_hdr;

   // ---- capture side: qualify events, reg writeback wins over a store
   assign w_reg_evt = enable & reg_write & (write_reg != 5'd0);
   assign w_st_evt  = enable & mem_write & ~w_reg_evt;
   assign w_evt     = w_reg_evt | w_st_evt;
   assign w_full    = (r_count == FULL_CNT);
   assign w_empty   = (r_count == '0);
   // Fullness is judged on the registered count, so a same-cycle pop does
   // not make room for a push.
   assign w_push    = w_evt & ~w_full;
   assign w_drop    = w_evt & w_full;

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem_type[r_wptr] <= w_st_evt;
         r_mem_reg[r_wptr]  <= w_reg_evt ? write_reg : 5'd0;
         r_mem_seq[r_wptr]  <= r_seq;
         r_mem_pc[r_wptr]   <= pc_out;
         r_mem_val[r_wptr]  <= w_reg_evt ? write_data : alu_result;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
         r_seq   <= 8'd0;
         r_drop  <= 8'd0;
      end else begin
         if (w_push) begin
            r_wptr <= r_wptr + 1'b1;
            r_seq  <= r_seq + 8'd1;
         end
         if (w_pop) begin
            r_rptr <= r_rptr + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
         // The pop hands the drop count to the outgoing header; a drop in
         // the same cycle belongs to the next header.
         if (w_pop) begin
            r_drop <= w_drop ? 8'd1 : 8'd0;
         end else if (w_drop) begin
            r_drop <= sat_inc8(r_drop);
         end
      end
   end

   // ---- serializer: header built from the FIFO head at pop time
   assign w_hdr = {4'hA, r_mem_type[r_rptr], r_mem_reg[r_rptr],
                   r_mem_seq[r_rptr], r_drop, 6'd0};
   assign w_xfer = r_out_valid & out_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_pop       = 1'b0;
      w_load_hdr  = 1'b0;
      w_load_pc   = 1'b0;
      w_load_val  = 1'b0;
      w_clr_valid = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (!w_empty) begin
               w_pop       = 1'b1;
               w_load_hdr  = 1'b1;
               w_state_nxt = S_HDR;
            end
         end
         S_HDR: begin
            if (w_xfer) begin
               w_load_pc   = 1'b1;
               w_state_nxt = S_PC;
            end
         end
         S_PC: begin
            if (w_xfer) begin
               w_load_val  = 1'b1;
               w_state_nxt = S_VAL;
            end
         end
         S_VAL: begin
            if (w_xfer) begin
               // Chain straight into the next record when one is waiting.
               if (!w_empty) begin
                  w_pop       = 1'b1;
                  w_load_hdr  = 1'b1;
                  w_state_nxt = S_HDR;
               end else begin
                  w_clr_valid = 1'b1;
                  w_state_nxt = S_IDLE;
               end
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_out_valid <= 1'b0;
         r_out_data  <= 32'd0;
      end else begin
         if (w_load_hdr) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_hdr;
         end else if (w_load_pc) begin
            r_out_data  <= r_cur_pc;
         end else if (w_load_val) begin
            r_out_data  <= r_cur_val;
         end else if (w_clr_valid) begin
            r_out_valid <= 1'b0;
         end
      end
   end

   // The popped entry leaves the FIFO, so its PC/value words are held here.
   always_ff @(posedge clk) begin
      if (w_pop) begin
         r_cur_pc  <= r_mem_pc[r_rptr];
         r_cur_val <= r_mem_val[r_rptr];
      end
   end

   assign out_valid  = r_out_valid;
   assign out_data   = r_out_data;
   assign fifo_count = r_count;

endmodule

// File: doc/mips_trace_capture.md
# mips_trace_capture

Synthesizable commit-trace monitor attached to the debug outputs of the single-cycle MIPS core, i.e. the receiving end of `pc_out`/`reg_write`/`write_reg`/`write_data`/`mem_write`/`alu_result`. Each architectural side effect (register writeback to a non-zero register, or data-memory store) is captured into a FIFO. Captured events are serialized as 3-word records on a 32-bit valid/ready stream for a UART/debug bridge or a bench-side scoreboard. Drops under back-pressure are counted and reported in-band.

## Interface
- `DEPTH`, 8: FIFO entries (power of two, ≥2).
- `clk` input 1: sole clock, rising edge.
- `reset` input 1: synchronous, active-high.
- `enable` input 1: capture enable; serialization continues when low.
- `pc_out` input 32: PC of the instruction in the current cycle.
- `reg_write` input 1: register writeback this cycle.
- `write_reg` input 5: destination register index.
- `write_data` input 32: writeback value.
- `mem_write` input 1: store this cycle.
- `alu_result` input 32: store address when `mem_write`=1.
- `out_valid` output 1: `out_data` holds a valid word.
- `out_ready` input 1: consumer accepts the word.
- `out_data` output 32: record word.
- `fifo_count` output $clog2(DEPTH)+1: current FIFO occupancy.

## Operation
- Event qualification, sampled each rising edge with `enable`=1:
  - Reg event: `reg_write`=1 and `write_reg`≠0.
  - Store event: `mem_write`=1 and no reg event in the same cycle. Reg events take priority; an ignored store is not counted as a drop.
- FIFO entry: {type, reg[4:0], pc[31:0], value[31:0]}.
  - value is `write_data` for reg events and `alu_result` for store events.
  - reg is 0 for store events.
- Push is accepted only if `fifo_count`<`DEPTH`, even when a pop occurs in the same cycle.
  - Accepted push: `seq` (8-bit) increments and wraps 255→0.
  - Rejected push: `drop_cnt` (8-bit) increments and saturates at 255. `seq` is unchanged.
- Record format, 3 words in order:
  - Header: [31:28]=4'hA; [27]=type (0 reg, 1 store); [26:22]=reg; [21:14]=seq value assigned at push; [13:6]=drop snapshot; [5:0]=0.
  - PC word.
  - Value word.
- Drop snapshot: when the FSM pops an entry, `drop_cnt` is copied into the header and cleared in the same cycle. A drop in that same cycle leaves `drop_cnt`=1.
- FSM states: IDLE, HDR, PC, VAL.
  - IDLE: if FIFO is non-empty, pop, load the header into `out_data`, set `out_valid`=1, go to HDR.
  - HDR: on valid&ready, load the PC word, go to PC.
  - PC: on valid&ready, load the value word, go to VAL.
  - VAL: on valid&ready, if FIFO is non-empty, pop and load the next header (stay on the record path via HDR, no bubble); otherwise `out_valid`=0 and go to IDLE.
- `out_data` and `out_valid` are registered. `out_data` is held stable while `out_valid`=1 and `out_ready`=0. `out_valid` never drops before a transfer.

## Timing
- Reset values:
  - `out_valid`=0, `out_data`=0, `fifo_count`=0.
  - FSM=IDLE, `seq`=0, `drop_cnt`=0.
  - Events presented during reset are ignored.
- Reset mid-record discards the partial record and all FIFO contents. The stream restarts cleanly with a header.
- Latency, FSM idle and FIFO empty: an event in cycle k is pushed at the end of k, popped at the end of k+1, and its header appears with `out_valid`=1 in cycle k+2.
- Throughput: with `out_ready` held at 1, one word per cycle, so one record every 3 cycles. Back-to-back records have no idle cycle.
- `fifo_count` updates the cycle after a push or pop. A simultaneous push and pop leaves the count unchanged.
- `enable` affects only the capture side. Deasserting it mid-record does not stop the drain.

## Test plan
- Single event, `out_ready`=1: reg write $3=0x0000000F at PC 0x8, sampled at the end of cycle 0. Required:
  - Cycle 2: header 0xA0C00000 (type 0, reg 3, seq 0, drop 0).
  - Cycle 3: 0x00000008.
  - Cycle 4: 0x0000000F.
  - Cycle 5: `out_valid`=0.
- Filtering:
  - Reg write to $0 produces no record.
  - Simultaneous `reg_write`+`mem_write` produces one type-0 record.
  - Store to address 0x40 produces header type 1 with reg 0 and value word 0x40.
- Back-pressure: hold `out_ready`=0 for 5 cycles mid-PC-word. Required: `out_data` and `out_valid` remain constant; the transfer completes the cycle after `out_ready` rises.
- Overflow, DEPTH=8, `out_ready`=0: 12 consecutive reg events (cycles 0–11), then release. Required:
  - Event 0 header: seq 0, drop 0.
  - Event 1 header: seq 1, drop 3.
  - Events 2–8: drop 0.
  - Exactly 9 records total.
- Sequence wrap: 257 spaced events. Required: seq runs 0…255, 0 with no drops.
- Reset mid-record: assert `reset` for 1 cycle during the PC word with 4 entries queued. Required:
  - Next cycle: `out_valid`=0 and `fifo_count`=0.
  - A following event emits seq 0.
